button_debounce: RTL and testbench
==================================

# button_debounce

Debounces one mechanical keypad or pushbutton input for the RPN calculator front end. It consumes the periodic strobe from `enable_gen` and produces a clean level plus single-cycle press and release pulses, with optional auto-repeat while the button is held. One instance sits between each raw button pin and the calculator's input decoder.

## Interface
- `STABLE_TICKS`, default 4: consecutive `enable_in` ticks of unchanged input needed to accept a level change; legal range ≥ 1.
- `REPEAT_TICKS`, default 0: `enable_in` ticks between auto-repeat `press_pulse`s while held; 0 disables repeat.
- `clk`  in  1  system clock; the block has one clock.
- `reset`  in  1  synchronous, active-low reset.
- `enable_in`  in  1  sample strobe, one `clk` wide, from `enable_gen`; tied 1 means every clock is a tick.
- `btn_raw`  in  1  asynchronous raw button, 1 = pressed.
- `btn_level`  out  1  debounced button state.
- `press_pulse`  out  1  one-cycle pulse on accepted press and on each auto-repeat.
- `release_pulse`  out  1  one-cycle pulse on accepted release.

## Operation
- **Synchronizer.** Two-flop synchronizer: `btn_raw` → `s1` → `btn_sync`. All decisions use `btn_sync`.
- **State machine.** States are IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT. There is a stability counter `cnt` and a repeat counter `rcnt`. Counter widths are $clog2(max param)+1 bits, and counters saturate or clear; they never wrap.
- **IDLE.** `btn_level`=0. If `btn_sync`=1, go to PRESS_WAIT with `cnt`=0.
- **PRESS_WAIT.**
  - If `btn_sync`=0 on any clock, go to IDLE and clear `cnt`; this is a bounce and produces no pulse.
  - Else, if `enable_in`=1: when `cnt`=STABLE_TICKS-1, go to PRESSED; otherwise `cnt`++.
- **PRESSED.**
  - `btn_level`=1.
  - If `btn_sync`=0, go to RELEASE_WAIT with `cnt`=0 and `rcnt`=0.
  - Else, if REPEAT_TICKS>0 and `enable_in`=1: when `rcnt`=REPEAT_TICKS-1, assert `press_pulse` and set `rcnt`=0; otherwise `rcnt`++.
- **RELEASE_WAIT.**
  - `btn_level` stays 1.
  - If `btn_sync`=1, return to PRESSED with `rcnt`=0 and no pulse.
  - Else, if `enable_in`=1: when `cnt`=STABLE_TICKS-1, go to IDLE; otherwise `cnt`++.
- **Output pulses.**
  - The PRESS_WAIT→PRESSED transition sets `btn_level`=1 and `press_pulse`=1 on the same edge.
  - The RELEASE_WAIT→IDLE transition sets `btn_level`=0 and `release_pulse`=1 on the same edge.
- **Precedence.** If `btn_sync` disagrees on the same cycle as `enable_in`=1, the bounce rule wins and no tick is counted.
- **Pulse exclusivity.** `press_pulse` and `release_pulse` are never high together, and each is never high for two consecutive cycles.

## Timing
- All outputs are registered.
- **Reset.** Reset values: `btn_level`=0, `press_pulse`=0, `release_pulse`=0. The synchronizer flops, `cnt` and `rcnt` clear to 0, and the state goes to IDLE.
- **Reset mid-operation.** Reset takes effect at the next edge while `reset`=0, in any state. Reset while PRESSED drops `btn_level` with no `release_pulse`.
- **Held through reset.** A button held through reset is re-debounced after reset and emits `press_pulse`.
- **Synchronizer latency.** `btn_raw` change at edge M appears on `btn_sync` after edge M+2.
- **Latency with `enable_in` tied 1.** Press at edge M gives `press_pulse` high in cycle M+STABLE_TICKS+3 (M+7 at default). Release follows the same formula for `release_pulse`.
- **Latency with a sparse `enable_in`.** Acceptance needs STABLE_TICKS `enable_in` ticks after entering the WAIT state, plus one edge.
- **Auto-repeat.** The first repeat comes REPEAT_TICKS ticks after the initial `press_pulse`, then every REPEAT_TICKS ticks.
- **`enable_in` width.** Held high for multiple cycles, it counts once per cycle.

## Test plan
- **Reset.** Assert `reset`=0 for 3 cycles with `btn_raw`=1 → all outputs 0. Release reset with `enable_in`=1 and STABLE_TICKS=4 → `press_pulse` exactly one cycle, 7 cycles after reset deassertion, and `btn_level`=1 thereafter.
- **Clean press/release.** `enable_in`=1, `btn_raw` rises at cycle 10 → `press_pulse` at cycle 17. `btn_raw` falls at cycle 30 → `release_pulse` at cycle 37 and `btn_level`=0 from 37.
- **Bounce rejection.** `btn_raw` toggles 1,0,1,0 every 2 cycles, then settles 1 → exactly one `press_pulse`, 7 cycles after settling; no `release_pulse`.
- **Sparse strobe.** `enable_in` every 10th cycle, `btn_raw` held 1 → `press_pulse` after the 4th tick following the PRESS_WAIT entry. A 0 glitch between ticks 2 and 3 → no press; the count restarts.
- **Auto-repeat.** REPEAT_TICKS=3, `enable_in`=1, held 20 cycles → initial press then a `press_pulse` every 3 cycles. A release glitch shorter than 4 ticks → no `release_pulse`, and the repeat cadence restarts.
- **Reset while PRESSED.** Assert `reset` while PRESSED → `btn_level` 0 at the next edge, no `release_pulse`.

Source files
------------

// File: rtl/button_debounce.sv
// Debounces one raw pushbutton using a sampled stability count and produces a clean level.
// It also emits single-cycle press/release pulses, with optional auto-repeat while held.
module button_debounce #(
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_in,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int MAX_TICKS = (STABLE_TICKS > REPEAT_TICKS) ? STABLE_TICKS : REPEAT_TICKS;
    localparam int CW        = $clog2(MAX_TICKS) + 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rcnt, rcnt_n;
    logic          level_n, press_n, release_n;
    logic          s1, btn_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn_raw;
            btn_sync <= s1;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n   = state;
        cnt_n     = cnt;
        rcnt_n    = rcnt;
        press_n   = 1'b0;
        release_n = 1'b0;

        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (enable_in) begin
                    if (cnt == STABLE_LAST) begin
                        state_n = PRESSED;
                        rcnt_n  = '0;
                        press_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                    rcnt_n  = '0;
                end else if (REPEAT_TICKS > 0 && enable_in) begin
                    if (rcnt == REPEAT_LAST) begin
                        rcnt_n  = '0;
                        // With REPEAT_TICKS=1 this keeps press pulses from touching back to back.
                        press_n = !press_pulse;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_n = PRESSED;
                    rcnt_n  = '0;
                end else if (enable_in) begin
                    if (cnt == STABLE_LAST) begin
                        state_n   = IDLE;
                        release_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        level_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            rcnt          <= rcnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: stimulus queues expected pulse events (kind + cycle),
// and a negedge monitor pops and compares them whenever a DUT emits a pulse.
module tb_button_debounce;

    logic clk;
    logic reset;
    logic enable_in;
    logic btn_a, btn_b;
    logic level_a, press_a, release_a;
    logic level_b, press_b, release_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    int code_a, code_b;
    int c;

    button_debounce dut_a (
        .clk           (clk),
        .reset         (reset),
        .enable_in     (enable_in),
        .btn_raw       (btn_a),
        .btn_level     (level_a),
        .press_pulse   (press_a),
        .release_pulse (release_a)
    );

    button_debounce #(.STABLE_TICKS(4), .REPEAT_TICKS(3)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .enable_in     (enable_in),
        .btn_raw       (btn_b),
        .btn_level     (level_b),
        .press_pulse   (press_b),
        .release_pulse (release_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event code: kind (1 = press, 2 = release) * 1e6 + edge number that set the pulse.
    function automatic int ev_press(input int cy);
        return 1000000 + cy;
    endfunction

    function automatic int ev_release(input int cy);
        return 2000000 + cy;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (press_a === 1'b1 || release_a === 1'b1) begin
            code_a = (press_a === 1'b1) ? ev_press(cyc) : ev_release(cyc);
            if (press_a === 1'b1 && release_a === 1'b1) check("a_pulse_overlap", 1, 0);
            if (q_a.size() == 0) check("a_unexpected_event", code_a, 0);
            else                 check("a_event", code_a, q_a.pop_front());
        end
        if (press_b === 1'b1 || release_b === 1'b1) begin
            code_b = (press_b === 1'b1) ? ev_press(cyc) : ev_release(cyc);
            if (press_b === 1'b1 && release_b === 1'b1) check("b_pulse_overlap", 1, 0);
            if (q_b.size() == 0) check("b_unexpected_event", code_b, 0);
            else                 check("b_event", code_b, q_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        enable_in = 1'b1;
        btn_a     = 1'b1;
        btn_b     = 1'b0;

        // Reset with button held; button re-debounces after reset.
        step(3);
        check("rst_level", level_a, 0);
        check("rst_press", press_a, 0);
        check("rst_release", release_a, 0);
        check("rst_level_b", level_b, 0);
        c = cyc;
        reset = 1'b1;
        q_a.push_back(ev_press(c + 7));
        step(12);
        check("held_reset_level", level_a, 1);

        // Reset while pressed: level drops, no release pulse.
        reset = 1'b0;
        btn_a = 1'b0;
        step(1);
        check("rst_pressed_level", level_a, 0);
        check("rst_pressed_release", release_a, 0);
        step(2);
        reset = 1'b1;
        step(5);
        check("post_rst_level", level_a, 0);

        // Clean press and release.
        c = cyc;
        btn_a = 1'b1;
        q_a.push_back(ev_press(c + 7));
        step(20);
        check("clean_level_high", level_a, 1);
        c = cyc;
        btn_a = 1'b0;
        q_a.push_back(ev_release(c + 7));
        step(6);
        check("release_not_early", level_a, 1);
        step(1);
        check("release_level_low", level_a, 0);
        step(5);

        // Bounce 1,0,1,0 then settle high.
        for (int i = 0; i < 4; i++) begin
            btn_a = (i % 2 == 0);
            step(2);
        end
        c = cyc;
        btn_a = 1'b1;
        q_a.push_back(ev_press(c + 7));
        step(12);
        check("bounce_level", level_a, 1);
        c = cyc;
        btn_a = 1'b0;
        q_a.push_back(ev_release(c + 7));
        step(12);

        // Sparse strobe: enable every 10th cycle, 4 ticks after PRESS_WAIT entry.
        c = cyc;
        q_a.push_back(ev_press(c + 40));
        for (int k = 0; k < 45; k++) begin
            enable_in = (k % 10 == 9);
            btn_a     = 1'b1;
            step(1);
        end
        check("sparse_level", level_a, 1);
        enable_in = 1'b1;
        c = cyc;
        btn_a = 1'b0;
        q_a.push_back(ev_release(c + 7));
        step(12);

        // Sparse strobe with a glitch between ticks 2 and 3: count restarts.
        c = cyc;
        q_a.push_back(ev_press(c + 60));
        for (int k = 0; k < 65; k++) begin
            enable_in = (k % 10 == 9);
            btn_a     = (k != 23);
            step(1);
        end
        check("sparse_glitch_level", level_a, 1);
        enable_in = 1'b1;
        c = cyc;
        btn_a = 1'b0;
        q_a.push_back(ev_release(c + 7));
        step(12);

        // Auto-repeat every 3 ticks; a short release glitch restarts the cadence.
        c = cyc;
        q_b.push_back(ev_press(c + 7));
        q_b.push_back(ev_press(c + 10));
        q_b.push_back(ev_press(c + 13));
        q_b.push_back(ev_press(c + 16));
        q_b.push_back(ev_press(c + 23));
        q_b.push_back(ev_press(c + 26));
        q_b.push_back(ev_press(c + 29));
        q_b.push_back(ev_press(c + 32));
        q_b.push_back(ev_release(c + 37));
        for (int k = 0; k < 45; k++) begin
            btn_b = (k < 15) || (k >= 17 && k < 30);
            step(1);
        end
        check("repeat_final_level", level_b, 0);

        step(5);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
